// File: rtl/acq_pkg.sv
// Shared types and widths for the acquisition sequencer.
// The optional beat watchdog is enabled with the ACQ_SEQ_TIMEOUT_EN macro.
package acq_pkg;

    localparam int LEN_W = 32;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_STOP  = 3'd4
    } acq_state_e;

    // Why the current run is being wound down; applied to the sticky flags on STOP exit.
    typedef enum logic [1:0] {
        CAUSE_DONE    = 2'd0,
        CAUSE_ABORT   = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } stop_cause_e;

endpackage

// File: rtl/acq_hold_timer.sv
// Loadable down-counter timing the FLUSH and STOP hold periods.
// expired is high while the count sits at zero.
module acq_hold_timer #(
    parameter int W = 4
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/acq_sequencer.sv
// Run sequencer for a stream packetizer: flush, arm, run, stop, with sticky status.
// Define ACQ_SEQ_TIMEOUT_EN to build in the beat watchdog.
//
// Stream snoop: a beat is transferred on a cycle where mon_tvalid and mon_tready
// are both high; that beat ends a packet when mon_tlast is also high.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int FLUSH_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    input  logic [LEN_W-1:0] cfg_packet_len,
    input  logic [CNT_W-1:0] cfg_num_packets,
    input  logic             mon_tvalid,
    input  logic             mon_tready,
    input  logic             mon_tlast,
    output logic             pkt_aresetn,
    output logic [LEN_W-1:0] pkt_config_reg,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err_cfg,
    output logic             err_timeout,
    output logic             irq,
    output logic [CNT_W-1:0] packets_done,
    output logic [2:0]       dbg_state
);

    localparam int HOLD_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FLUSH_CYCLES - 1);

    acq_state_e       state, state_nxt;
    stop_cause_e      cause_q, cause_nxt;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             hold_load, hold_expired;
    logic             pkt_end, last_pkt, timeout_hit, start_ok;

    assign start_ok = cmd_start && (cfg_packet_len != '0);
    assign pkt_end  = (state == ST_RUN) && mon_tvalid && mon_tready && mon_tlast;
    assign cnt_inc  = (packets_done == '1) ? packets_done : packets_done + CNT_W'(1);
    assign last_pkt = pkt_end && (num_q != '0) && (cnt_inc == num_q);

    acq_hold_timer #(.W(HOLD_W)) u_hold (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .expired  (hold_expired)
    );

    // Abort outranks completion and timeout when they land on the same cycle.
    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        hold_load = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_FLUSH;
                    hold_load = 1'b1;
                end
            end
            ST_FLUSH, ST_ARM: begin
                if (cmd_abort) begin
                    state_nxt = ST_STOP;
                    cause_nxt = CAUSE_ABORT;
                    hold_load = 1'b1;
                end else if (state == ST_ARM) begin
                    state_nxt = ST_RUN;
                end else if (hold_expired) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_RUN: begin
                if (cmd_abort || last_pkt || timeout_hit) begin
                    state_nxt = ST_STOP;
                    hold_load = 1'b1;
                    if (cmd_abort)     cause_nxt = CAUSE_ABORT;
                    else if (last_pkt) cause_nxt = CAUSE_DONE;
                    else               cause_nxt = CAUSE_TIMEOUT;
                end
            end
            ST_STOP: begin
                if (hold_expired) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= ST_IDLE;
            cause_q        <= CAUSE_DONE;
            pkt_aresetn    <= 1'b0;
            pkt_config_reg <= '0;
        end else begin
            state          <= state_nxt;
            cause_q        <= cause_nxt;
            pkt_aresetn    <= (state_nxt == ST_ARM) || (state_nxt == ST_RUN);
            pkt_config_reg <= (state_nxt == ST_RUN) ? len_q : '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            len_q        <= '0;
            num_q        <= '0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            err_cfg      <= 1'b0;
            irq          <= 1'b0;
            packets_done <= '0;
        end else begin
            irq <= (state == ST_STOP) && hold_expired;
            if (state == ST_IDLE && cmd_start) begin
                if (cfg_packet_len == '0) begin
                    err_cfg <= 1'b1;
                end else begin
                    len_q        <= cfg_packet_len;
                    num_q        <= cfg_num_packets;
                    done         <= 1'b0;
                    aborted      <= 1'b0;
                    err_cfg      <= 1'b0;
                    packets_done <= '0;
                end
            end
            if (pkt_end) packets_done <= cnt_inc;
            if (state == ST_STOP && hold_expired) begin
                if (cause_q == CAUSE_DONE)  done    <= 1'b1;
                if (cause_q == CAUSE_ABORT) aborted <= 1'b1;
            end
        end
    end

`ifdef ACQ_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic            beat;

    assign beat        = mon_tvalid && mon_tready;
    assign timeout_hit = (state == ST_RUN) && !beat && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Counts consecutive RUN cycles without a transferred beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wd_q <= '0;
        end else if (state != ST_RUN || beat) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_timeout <= 1'b0;
        end else if (state == ST_IDLE && start_ok) begin
            err_timeout <= 1'b0;
        end else if (state == ST_STOP && hold_expired && cause_q == CAUSE_TIMEOUT) begin
            err_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: timeline-based reference model with per-cycle compare.
// Build with ACQ_SEQ_TIMEOUT_EN defined to exercise the beat watchdog.
module tb_acq_sequencer;

    localparam int F  = 4;
    localparam int TO = 16;
`ifdef ACQ_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        aclk, aresetn;
    logic        cmd_start, cmd_abort;
    logic [31:0] cfg_packet_len;
    logic [15:0] cfg_num_packets;
    logic        mon_tvalid, mon_tready, mon_tlast;
    logic        pkt_aresetn;
    logic [31:0] pkt_config_reg;
    logic        busy, done, aborted, err_cfg, err_timeout, irq;
    logic [15:0] packets_done;
    logic [2:0]  dbg_state;

    acq_sequencer #(.FLUSH_CYCLES(F), .TIMEOUT_CYCLES(TO)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .cmd_start       (cmd_start),
        .cmd_abort       (cmd_abort),
        .cfg_packet_len  (cfg_packet_len),
        .cfg_num_packets (cfg_num_packets),
        .mon_tvalid      (mon_tvalid),
        .mon_tready      (mon_tready),
        .mon_tlast       (mon_tlast),
        .pkt_aresetn     (pkt_aresetn),
        .pkt_config_reg  (pkt_config_reg),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .err_cfg         (err_cfg),
        .err_timeout     (err_timeout),
        .irq             (irq),
        .packets_done    (packets_done),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A run is described by when it started flushing (m_fl) and when it began
    // stopping (m_stop_at); every output follows from those timestamps.
    localparam int C_DONE = 0, C_ABORT = 1, C_TO = 2;
    localparam int R_IDLE = 0, R_FL = 1, R_ARM = 2, R_RUN = 3, R_STOP = 4;

    int cyc = 0;
    bit m_act, m_stop_set;
    int m_fl, m_stop_at, m_cause, m_len, m_num, m_cnt, m_wd;
    bit m_done, m_abort, m_errcfg, m_errto, m_irq;

    function automatic int region(input int e);
        if (!m_act) return R_IDLE;
        if (!m_stop_set || e < m_stop_at) begin
            if (e - m_fl < F)  return R_FL;
            if (e - m_fl == F) return R_ARM;
            return R_RUN;
        end
        if (e - m_stop_at < F) return R_STOP;
        return R_IDLE;
    endfunction

    task automatic model_reset();
        m_act = 0; m_stop_set = 0; m_fl = 0; m_stop_at = 0; m_cause = C_DONE;
        m_len = 0; m_num = 0; m_cnt = 0; m_wd = 0;
        m_done = 0; m_abort = 0; m_errcfg = 0; m_errto = 0; m_irq = 0;
    endtask

    task automatic go_stop(input int k, input int cause);
        m_stop_set = 1; m_stop_at = k; m_cause = cause;
    endtask

    task automatic model_step(input int k);
        int  r;
        bit  beat, ended;
        r     = region(k - 1);
        m_irq = 0;
        beat  = mon_tvalid && mon_tready;
        if (r != R_RUN) m_wd = 0;
        case (r)
            R_IDLE: if (cmd_start) begin
                if (cfg_packet_len == 0) m_errcfg = 1;
                else begin
                    m_len = int'(cfg_packet_len); m_num = int'(cfg_num_packets);
                    m_cnt = 0; m_done = 0; m_abort = 0; m_errcfg = 0; m_errto = 0;
                    m_act = 1; m_fl = k; m_stop_set = 0; m_wd = 0;
                end
            end
            R_FL, R_ARM, R_RUN: begin
                ended = (r == R_RUN) && beat && mon_tlast;
                if (ended && m_cnt < 65535) m_cnt++;
                if (cmd_abort) go_stop(k, C_ABORT);
                else if (ended && m_num != 0 && m_cnt == m_num) go_stop(k, C_DONE);
                else if (TO_EN && r == R_RUN) begin
                    if (beat) m_wd = 0;
                    else begin
                        m_wd++;
                        if (m_wd == TO) go_stop(k, C_TO);
                    end
                end
            end
            R_STOP: if (k == m_stop_at + F) begin
                m_act = 0; m_irq = 1;
                if (m_cause == C_DONE)  m_done  = 1;
                if (m_cause == C_ABORT) m_abort = 1;
                if (m_cause == C_TO)    m_errto = 1;
            end
            default: ;
        endcase
    endtask

    // ---------------- scoreboard / monitors ----------------
    int irq_cnt, busy_cyc, low_pre_arm, max_cfg;
    bit seen_arm;

    task automatic clr_mon();
        irq_cnt = 0; busy_cyc = 0; low_pre_arm = 0; max_cfg = 0; seen_arm = 0;
    endtask

    initial begin
        model_reset();
        clr_mon();
        forever begin
            int r;
            @(posedge aclk);
            #1;
            cyc++;
            if (!aresetn) model_reset();
            else          model_step(cyc);
            r = region(cyc);
            chk("busy",           busy,           32'(r != R_IDLE));
            chk("pkt_aresetn",    pkt_aresetn,    32'(r == R_ARM || r == R_RUN));
            chk("pkt_config_reg", pkt_config_reg, (r == R_RUN) ? 32'(m_len) : 32'd0);
            chk("packets_done",   packets_done,   32'(m_cnt));
            chk("done",           done,           32'(m_done));
            chk("aborted",        aborted,        32'(m_abort));
            chk("err_cfg",        err_cfg,        32'(m_errcfg));
            chk("err_timeout",    err_timeout,    32'(m_errto));
            chk("irq",            irq,            32'(m_irq));
            if (irq) irq_cnt++;
            if (busy) busy_cyc++;
            if (pkt_aresetn) seen_arm = 1;
            if (busy && !pkt_aresetn && !seen_arm) low_pre_arm++;
            if (int'(pkt_config_reg) > max_cfg) max_cfg = int'(pkt_config_reg);
        end
    end

    // ---------------- stream driver ----------------
    // 0 quiet, 1 random, 2 stalled (tready low), 3 loopback full rate, 5 manual
    int mode = 0;
    int lb_len = 10;
    int lb_beats = 0;

    initial begin
        forever begin
            @(posedge aclk);
            #3;
            case (mode)
                0: begin mon_tvalid = 0; mon_tready = 0; mon_tlast = 0; end
                1: begin
                    mon_tvalid = 1'($urandom_range(0, 1));
                    mon_tready = 1'($urandom_range(0, 1));
                    mon_tlast  = ($urandom_range(0, 2) == 0);
                end
                2: begin mon_tvalid = 1; mon_tready = 0; mon_tlast = 1'($urandom_range(0, 1)); end
                3: begin
                    mon_tvalid = 1; mon_tready = 1;
                    mon_tlast  = (lb_beats % lb_len == lb_len - 1);
                    lb_beats++;
                end
                default: ;
            endcase
        end
    end

    // ---------------- command driver tasks ----------------
    task automatic start_cmd(input int len, input int num);
        @(negedge aclk);
        cfg_packet_len = 32'(len); cfg_num_packets = 16'(num); cmd_start = 1;
        @(negedge aclk);
        cmd_start = 0;
    endtask

    task automatic abort_now();
        @(negedge aclk); cmd_abort = 1;
        @(negedge aclk); cmd_abort = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge aclk); #2; n++;
        end
        n_checks++;
        if (busy) begin
            n_fail++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, budget);
        end
        repeat (2) @(negedge aclk);
    endtask

    task automatic wait_cfg(input string name, input int val, input int budget);
        int n = 0;
        while (int'(pkt_config_reg) != val && n < budget) begin
            @(posedge aclk); #2; n++;
        end
        chk(name, pkt_config_reg, 32'(val));
    endtask

    task automatic beat(input bit last, input bit abrt);
        @(negedge aclk);
        mon_tvalid = 1; mon_tready = 1; mon_tlast = last; cmd_abort = abrt;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        aresetn = 0; cmd_start = 0; cmd_abort = 0;
        cfg_packet_len = 0; cfg_num_packets = 0;
        mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
        repeat (3) @(negedge aclk);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_aresetn", pkt_aresetn, 0);
        chk("rst_packets_done", packets_done, 0);
        aresetn = 1;
        repeat (2) @(negedge aclk);

        // Basic run: len 10, three packets over a loopback stream.
        clr_mon(); lb_len = 10; lb_beats = 0; mode = 3;
        start_cmd(10, 3);
        wait_idle("run3_idle", 500);
        mode = 0;
        chk("run3_packets", packets_done, 3);
        chk("run3_done", done, 1);
        chk("run3_aborted", aborted, 0);
        chk("run3_irq_pulses", irq_cnt, 1);
        chk("run3_flush_len", low_pre_arm, 4);
        chk("run3_cfg_seen", max_cfg, 10);
        chk("run3_pkt_rst_idle", pkt_aresetn, 0);

        // Zero length is rejected.
        clr_mon();
        start_cmd(0, 5);
        repeat (5) @(negedge aclk);
        chk("len0_err_cfg", err_cfg, 1);
        chk("len0_busy", busy, 0);
        chk("len0_irq", irq_cnt, 0);
        chk("len0_pkt_rst", pkt_aresetn, 0);
        chk("len0_done_kept", done, 1);

        // Continuous run, abort after five packets.
        clr_mon(); lb_len = 10; lb_beats = 0; mode = 3;
        start_cmd(10, 0);
        begin
            int n = 0;
            while (packets_done != 5 && n < 500) begin @(posedge aclk); #2; n++; end
        end
        mode = 0;
        chk("abort5_reached", packets_done, 5);
        @(negedge aclk); cmd_abort = 1;
        @(posedge aclk); #2;
        chk("abort5_cfg_zero", pkt_config_reg, 0);
        @(negedge aclk); cmd_abort = 0;
        wait_idle("abort5_idle", 100);
        chk("abort5_packets", packets_done, 5);
        chk("abort5_aborted", aborted, 1);
        chk("abort5_done", done, 0);
        chk("abort5_irq", irq_cnt, 1);

        // Abort coinciding with the final tlast beat.
        clr_mon(); mode = 5;
        mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
        start_cmd(3, 2);
        wait_cfg("race_in_run", 3, 50);
        beat(0, 0); beat(0, 0); beat(1, 0); beat(0, 0); beat(1, 1);
        @(negedge aclk);
        mon_tvalid = 0; mon_tready = 0; mon_tlast = 0; cmd_abort = 0;
        mode = 0;
        wait_idle("race_idle", 100);
        chk("race_packets", packets_done, 2);
        chk("race_aborted", aborted, 1);
        chk("race_done", done, 0);

        // Asynchronous reset in the middle of a run.
        clr_mon(); lb_len = 10; lb_beats = 0; mode = 3;
        start_cmd(10, 0);
        wait_cfg("rstrun_in_run", 10, 50);
        repeat (3) @(posedge aclk);
        mode = 0;
        @(negedge aclk);
        aresetn = 0;
        #1;
        chk("rstrun_busy", busy, 0);
        chk("rstrun_pkt_aresetn", pkt_aresetn, 0);
        chk("rstrun_cfg", pkt_config_reg, 0);
        chk("rstrun_packets", packets_done, 0);
        chk("rstrun_aborted", aborted, 0);
        chk("rstrun_irq", irq, 0);
        repeat (2) @(negedge aclk);
        aresetn = 1;
        chk("rstrun_no_irq", irq_cnt, 0);
        clr_mon(); lb_beats = 0; mode = 3;
        start_cmd(10, 3);
        wait_idle("rstrun_rerun_idle", 500);
        mode = 0;
        chk("rstrun_rerun_done", done, 1);
        chk("rstrun_rerun_packets", packets_done, 3);
        chk("rstrun_rerun_irq", irq_cnt, 1);

        // Randomized runs with mid-run noise on start/cfg/abort.
        for (int run = 0; run < 25; run++) begin
            int len, num;
            len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            num = $urandom_range(0, 4);
            mode = 1;
            start_cmd(len, num);
            for (int c = 0; c < 300; c++) begin
                @(negedge aclk);
                if (!busy) break;
                cmd_start       = ($urandom_range(0, 9) == 0);
                cfg_packet_len  = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
                cfg_num_packets = 16'($urandom);
                cmd_abort       = ($urandom_range(0, 49) == 0);
            end
            @(negedge aclk);
            cmd_start = 0; cmd_abort = 0;
            if (busy) abort_now();
            wait_idle("rand_idle", 100);
        end
        mode = 0;

`ifdef ACQ_SEQ_TIMEOUT_EN
        // Stalled stream trips the watchdog.
        repeat (2) @(negedge aclk);
        clr_mon(); mode = 2;
        start_cmd(10, 0);
        wait_idle("to_idle", 200);
        mode = 0;
        chk("to_err_timeout", err_timeout, 1);
        chk("to_aborted", aborted, 0);
        chk("to_done", done, 0);
        chk("to_irq", irq_cnt, 1);
        chk("to_busy_cycles", busy_cyc, F + 1 + TO + F);
`else
        chk("to_tied_low", err_timeout, 0);
`endif

        repeat (3) @(negedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 4, cycles the packetizer is held in reset before a run.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, beat-watchdog limit (used only per REQ-030).
REQ-003 SHALL have ports: aclk  in  1  clock; aresetn  in  1  async active-low reset.
REQ-004 SHALL have ports: cmd_start  in  1  start pulse; cmd_abort  in  1  abort pulse.
REQ-005 SHALL have ports: cfg_packet_len  in  32  words per packet; cfg_num_packets  in  16  packets per run, 0 = continuous.
REQ-006 SHALL have ports: mon_tvalid, mon_tready, mon_tlast  in  1 each  snoop of the packetizer S2MM output stream.
REQ-007 SHALL have ports: pkt_aresetn  out  1  packetizer reset; pkt_config_reg  out  32  packetizer packet length.
REQ-008 SHALL have ports: busy  out  1; done  out  1  sticky; aborted  out  1  sticky; err_cfg  out  1  sticky; err_timeout  out  1  sticky; irq  out  1  one-cycle pulse; packets_done  out  16.

Function
REQ-009 SHALL implement states IDLE, FLUSH, ARM, RUN, STOP.
REQ-010 IDLE + cmd_start + cfg_packet_len != 0 SHALL latch cfg_packet_len and cfg_num_packets, clear done/aborted/err_cfg/err_timeout/packets_done, and enter FLUSH next cycle.
REQ-011 IDLE + cmd_start + cfg_packet_len == 0 SHALL set err_cfg, remain IDLE, and not pulse irq.
REQ-012 FLUSH SHALL drive pkt_aresetn=0 and pkt_config_reg=0 for exactly FLUSH_CYCLES cycles, then enter ARM.
REQ-013 ARM SHALL last one cycle with pkt_aresetn=1 and pkt_config_reg=0, then enter RUN.
REQ-014 RUN SHALL drive pkt_aresetn=1 and pkt_config_reg=latched length, registered (no combinational path from inputs).
REQ-015 A packet end SHALL be mon_tvalid & mon_tready & mon_tlast in RUN; each increments packets_done by 1.
REQ-016 packets_done SHALL saturate at 16'hFFFF in continuous mode.
REQ-017 When packets_done reaches latched cfg_num_packets (nonzero), the sequencer SHALL enter STOP on the next cycle.
REQ-018 STOP SHALL drive pkt_config_reg=0 and pkt_aresetn=0 for FLUSH_CYCLES cycles, then enter IDLE and pulse irq for one cycle.
REQ-019 The STOP-to-IDLE transition SHALL set done if entered by completion, aborted if by cmd_abort, err_timeout if by timeout.
REQ-020 cmd_abort in FLUSH, ARM or RUN SHALL enter STOP next cycle; cmd_abort in IDLE or STOP SHALL be ignored.
REQ-021 Simultaneous cmd_abort and final packet end: packets_done SHALL count the beat, abort SHALL take priority (aborted=1, done=0).
REQ-022 cmd_start outside IDLE SHALL be ignored; cfg_* changes outside IDLE SHALL have no effect.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 Beats without tlast SHALL NOT change packets_done.

Reset
REQ-025 aresetn low SHALL asynchronously force state IDLE, pkt_aresetn=0, pkt_config_reg=0, busy=0, done=0, aborted=0, err_cfg=0, err_timeout=0, irq=0, packets_done=0.
REQ-026 pkt_aresetn SHALL stay 0 in IDLE, so the packetizer is held in reset between runs.
REQ-027 Reset mid-run SHALL discard the run with no irq; release SHALL resume in IDLE.

Configuration
REQ-028 Macro ACQ_SEQ_TIMEOUT_EN SHALL compile the beat watchdog in or out.
REQ-029 Without ACQ_SEQ_TIMEOUT_EN: no watchdog counter; err_timeout SHALL be tied to 0.
REQ-030 With ACQ_SEQ_TIMEOUT_EN: in RUN, a counter clears on any mon_tvalid&mon_tready and otherwise increments; reaching TIMEOUT_CYCLES SHALL enter STOP with err_timeout cause.

Structure
REQ-031 A shared package acq_pkg SHALL hold the state enum typedef and the width constants (32 length, 16 count).
REQ-032 The FLUSH/STOP duration counter SHALL be a sub-module acq_hold_timer (load, count down, expired flag), reused for both states.

Verification
REQ-033 len=10, num=3, start; loopback stream -> pkt_aresetn low 4 cycles, config_reg=10 in RUN, packets_done=3, done=1, single irq pulse.
REQ-034 len=0, start -> err_cfg=1, busy stays 0, no irq, pkt_aresetn stays 0.
REQ-035 len=10, num=0, run 5 packets then abort -> packets_done=5, aborted=1, done=0, config_reg=0 within 1 cycle.
REQ-036 num=2, abort on same cycle as 2nd tlast beat -> packets_done=2, aborted=1, done=0.
REQ-037 aresetn pulsed low mid-RUN -> all outputs at reset values immediately, no irq; subsequent start completes normally.
REQ-038 With ACQ_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, tready held 0 in RUN -> err_timeout=1 after 16 idle cycles plus STOP, irq pulses once.
